// File: rtl/spi_flash_target.sv
// SPI mode-0 target emulating a serial boot flash. Decodes READ (03h),
// JEDEC ID (9Fh) and READ STATUS (05h) and serves READ data from an
// external synchronous ROM. SCK/CS/MOSI are oversampled in the system clock
// domain; nothing is clocked by SCK.
module spi_flash_target #(
  parameter int unsigned AW   = 16,
  parameter logic [23:0] ID   = 24'hEF4018,
  parameter logic [7:0]  STAT = 8'h00
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          spiCs,
  input  logic          spiCk,
  input  logic          spiDi,
  output logic          spiDo,
  output logic          memRd,
  output logic [AW-1:0] memA,
  input  logic [7:0]    memQ,
  output logic          busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_ID,
    ST_STAT,
    ST_IGNORE
  } state_t;

  localparam logic [AW-1:0] A_ONE = AW'(1);

  // Synchroniser and edge-history registers
  logic [1:0]  r_cs_s;
  logic [1:0]  r_ck_s;
  logic [1:0]  r_di_s;
  logic        r_cs_d;
  logic        r_ck_d;

  // Protocol state
  state_t      r_state;
  logic [2:0]  r_bitcnt;
  logic [6:0]  r_rx;
  logic [7:0]  r_tx;
  logic [15:0] r_addr;
  logic [1:0]  r_acnt;
  logic [1:0]  r_idx;
  logic        r_ld;

  logic        w_cs;
  logic        w_di;
  logic        w_ck_rise;
  logic        w_ck_fall;
  logic        w_cs_fall;
  logic        w_byte_done;
  logic [7:0]  w_byte;
  logic [23:0] w_addr;
  logic        w_unused_addr;

  assign w_cs        = r_cs_s[1];
  assign w_di        = r_di_s[1];
  assign w_ck_rise   = r_ck_s[1] & ~r_ck_d;
  assign w_ck_fall   = ~r_ck_s[1] & r_ck_d;
  assign w_cs_fall   = r_cs_d & ~w_cs;
  assign w_byte_done = w_ck_rise && (r_bitcnt == 3'd7);
  assign w_byte      = {r_rx, w_di};
  assign w_addr      = {r_addr, w_byte};
  // Only the low AW address bits reach the ROM; the rest are intentionally dropped.
  assign w_unused_addr = ^w_addr;

  assign busy = (r_state != ST_IDLE);

  // Two-flop synchronisers plus one history flop for edge detection.
  // CS history resets low so a transfer already under way at reset never
  // produces a CS-fall; CS must be seen high first.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cs_s <= '0;
      r_ck_s <= '0;
      r_di_s <= '0;
      r_cs_d <= 1'b0;
      r_ck_d <= 1'b0;
    end else begin
      r_cs_s <= {r_cs_s[0], spiCs};
      r_ck_s <= {r_ck_s[0], spiCk};
      r_di_s <= {r_di_s[0], spiDi};
      r_cs_d <= r_cs_s[1];
      r_ck_d <= r_ck_s[1];
    end
  end

  // Command FSM, bit/byte shifting, ROM handshake and MISO generation.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_rx     <= '0;
      r_tx     <= '0;
      r_addr   <= '0;
      r_acnt   <= '0;
      r_idx    <= '0;
      r_ld     <= 1'b0;
      spiDo    <= 1'b0;
      memRd    <= 1'b0;
      memA     <= '0;
    end else begin
      memRd <= 1'b0;
      r_ld  <= memRd;
      if (w_cs) begin
        // Deselect aborts everything; an in-flight ROM read is let to finish
        // but its data is never loaded.
        r_state  <= ST_IDLE;
        r_bitcnt <= '0;
        r_ld     <= 1'b0;
        spiDo    <= 1'b0;
      end else if (r_state == ST_IDLE) begin
        if (w_cs_fall) begin
          r_state  <= ST_CMD;
          r_bitcnt <= '0;
        end
      end else begin
        if (r_ld && (r_state == ST_DATA)) begin
          r_tx <= memQ;
        end

        if (w_ck_rise) begin
          r_rx     <= w_byte[6:0];
          r_bitcnt <= r_bitcnt + 3'd1;
        end

        if (w_ck_fall) begin
          if ((r_state == ST_DATA) || (r_state == ST_ID) || (r_state == ST_STAT)) begin
            spiDo <= r_tx[7];
            r_tx  <= {r_tx[6:0], 1'b0};
          end else begin
            spiDo <= 1'b0;
          end
        end

        if (w_byte_done) begin
          case (r_state)
            ST_CMD: begin
              case (w_byte)
                8'h03: begin
                  r_state <= ST_ADDR;
                  r_acnt  <= '0;
                end
                8'h9F: begin
                  r_state <= ST_ID;
                  r_tx    <= ID[23:16];
                  r_idx   <= 2'd1;
                end
                8'h05: begin
                  r_state <= ST_STAT;
                  r_tx    <= STAT;
                end
                default: r_state <= ST_IGNORE;
              endcase
            end
            ST_ADDR: begin
              r_addr <= {r_addr[7:0], w_byte};
              r_acnt <= r_acnt + 2'd1;
              if (r_acnt == 2'd2) begin
                memA    <= w_addr[AW-1:0];
                memRd   <= 1'b1;
                r_state <= ST_DATA;
              end
            end
            ST_DATA: begin
              memA  <= memA + A_ONE;
              memRd <= 1'b1;
            end
            ST_ID: begin
              case (r_idx)
                2'd1:    r_tx <= ID[15:8];
                2'd2:    r_tx <= ID[7:0];
                default: r_tx <= 8'h00;
              endcase
              if (r_idx != 2'd3) begin
                r_idx <= r_idx + 2'd1;
              end
            end
            ST_STAT: r_tx <= STAT;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
